// File: rtl/epmu_213_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | epmu_213_if : ACSU <-> path-metric unit bus bundle                       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface epmu_213_if #(
  parameter int W    = 8,
  parameter int SC_W = 6
);
  logic              start;
  logic              in_valid;
  logic [8*W-1:0]    acs_ppm_bus_in;
  logic [7:0]        acs_bx_bus_in;
  logic [8*W-1:0]    acs_ppm_ina_bus;
  logic [8*W-1:0]    acs_ppm_inb_bus;
  logic [7:0]        dec_out;
  logic              dec_valid;
  logic [2:0]        best_state;
  logic [SC_W-1:0]   stage_cnt;
  logic              norm_evt;
  logic              ovf;

  modport master (
    output start, in_valid, acs_ppm_bus_in, acs_bx_bus_in,
    input  acs_ppm_ina_bus, acs_ppm_inb_bus, dec_out, dec_valid,
           best_state, stage_cnt, norm_evt, ovf
  );

  modport slave (
    input  start, in_valid, acs_ppm_bus_in, acs_bx_bus_in,
    output acs_ppm_ina_bus, acs_ppm_inb_bus, dec_out, dec_valid,
           best_state, stage_cnt, norm_evt, ovf
  );
endinterface
`default_nettype wire

// File: rtl/epmu_213.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | epmu_213 : 8-state Viterbi path-metric store, routing and normalisation  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module epmu_213 #(
  parameter int W    = 8,
  parameter int SC_W = 6
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  epmu_213_if.slave   bus
);
  localparam logic [W-1:0] c_pm_init = {2'b01, {(W-2){1'b0}}};
  localparam logic [W-1:0] c_pm_max  = {W{1'b1}};

  logic [W-1:0]    pm_q [8];
  logic [W-1:0]    pm_d [8];
  logic [W-1:0]    in_m [8];
  logic [7:0]      dec_q, dec_d;
  logic            dec_valid_q, dec_valid_d;
  logic [2:0]      best_q, best_d;
  logic [SC_W-1:0] stage_q, stage_d;
  logic [SC_W-1:0] cnt_q, cnt_d;
  logic            norm_q, norm_d;
  logic            ovf_q, ovf_d;

  logic            all_msb;
  logic            any_max;
  logic [2:0]      min_idx;
  logic [W-1:0]    min_val;

  // Next state ns = {u, s[2:1]} is fed from predecessors 2s and 2s+1.
  for (genvar s = 0; s < 8; s++) begin : g_route
    assign in_m[s] = bus.acs_ppm_bus_in[s*W +: W];
    assign bus.acs_ppm_ina_bus[s*W +: W] = pm_q[(2*s) % 8];
    assign bus.acs_ppm_inb_bus[s*W +: W] = pm_q[(2*s+1) % 8];
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    all_msb = 1'b1;
    any_max = 1'b0;
    min_idx = 3'd0;
    min_val = in_m[0];
    for (int s = 0; s < 8; s++) begin
      all_msb = all_msb & in_m[s][W-1];
      any_max = any_max | (in_m[s] == c_pm_max);
      if (in_m[s] < min_val) begin
        min_val = in_m[s];
        min_idx = 3'(s);
      end
    end
  end

  always_comb begin
    pm_d        = pm_q;
    dec_d       = dec_q;
    dec_valid_d = 1'b0;
    best_d      = best_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    norm_d      = 1'b0;
    ovf_d       = ovf_q;
    if (bus.start) begin
      pm_d[0] = '0;
      for (int s = 1; s < 8; s++) pm_d[s] = c_pm_init;
      stage_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (bus.in_valid) begin
      // Subtracting 2^(W-1) from a value with its MSB set just clears the MSB.
      for (int s = 0; s < 8; s++)
        pm_d[s] = all_msb ? {1'b0, in_m[s][W-2:0]} : in_m[s];
      dec_d       = bus.acs_bx_bus_in;
      dec_valid_d = 1'b1;
      best_d      = min_idx;
      stage_d     = cnt_q;
      cnt_d       = cnt_q + SC_W'(1);
      norm_d      = all_msb;
      ovf_d       = ovf_q | any_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pm_q[0] <= '0;
      for (int s = 1; s < 8; s++) pm_q[s] <= c_pm_init;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      best_q      <= '0;
      stage_q     <= '0;
      cnt_q       <= '0;
      norm_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int s = 0; s < 8; s++) pm_q[s] <= pm_d[s];
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      best_q      <= best_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      norm_q      <= norm_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.dec_out    = dec_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.best_state = best_q;
  assign bus.stage_cnt  = stage_q;
  assign bus.norm_evt   = norm_q;
  assign bus.ovf        = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_epmu_213.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_epmu_213 : model-checked directed bench for epmu_213 (W=8, SC_W=6)    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_epmu_213;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  epmu_213_if #(.W(8), .SC_W(6)) bus ();
  epmu_213 #(.W(8), .SC_W(6)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers, updated on each rising edge.
  int m_pm [8];
  int m_dec, m_dv, m_best, m_stage, m_cnt, m_norm, m_ovf;

  always @(posedge clk) begin
    int v [8];
    int allhi, best;
    if (!reset_n) begin
      m_pm[0] = 0;
      for (int s = 1; s < 8; s++) m_pm[s] = 64;
      m_dec = 0; m_dv = 0; m_best = 0; m_stage = 0; m_cnt = 0; m_norm = 0; m_ovf = 0;
    end else if (bus.start) begin
      m_pm[0] = 0;
      for (int s = 1; s < 8; s++) m_pm[s] = 64;
      m_stage = 0; m_cnt = 0; m_ovf = 0; m_dv = 0; m_norm = 0;
    end else if (bus.in_valid) begin
      allhi = 1;
      best  = 0;
      for (int s = 0; s < 8; s++) begin
        v[s] = int'(bus.acs_ppm_bus_in[s*8 +: 8]);
        if (v[s] < 128) allhi = 0;
        if (v[s] == 255) m_ovf = 1;
      end
      for (int s = 1; s < 8; s++) if (v[s] < v[best]) best = s;
      for (int s = 0; s < 8; s++) m_pm[s] = allhi ? v[s] - 128 : v[s];
      m_dec   = int'(bus.acs_bx_bus_in);
      m_best  = best;
      m_stage = m_cnt;
      m_cnt   = (m_cnt + 1) % 64;
      m_dv    = 1;
      m_norm  = allhi;
    end else begin
      m_dv = 0;
      m_norm = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_pm(input int k);
    if (k % 2 == 0) return int'(bus.acs_ppm_ina_bus[(k/2)*8 +: 8]);
    return int'(bus.acs_ppm_inb_bus[((k-1)/2)*8 +: 8]);
  endfunction

  task automatic compare_model();
    for (int s = 0; s < 8; s++) begin
      chk($sformatf("ina[%0d]", s), int'(bus.acs_ppm_ina_bus[s*8 +: 8]), m_pm[(2*s) % 8]);
      chk($sformatf("inb[%0d]", s), int'(bus.acs_ppm_inb_bus[s*8 +: 8]), m_pm[(2*s+1) % 8]);
    end
    chk("dec_valid",  int'(bus.dec_valid),  m_dv);
    chk("norm_evt",   int'(bus.norm_evt),   m_norm);
    chk("ovf",        int'(bus.ovf),        m_ovf);
    chk("dec_out",    int'(bus.dec_out),    m_dec);
    chk("best_state", int'(bus.best_state), m_best);
    chk("stage_cnt",  int'(bus.stage_cnt),  m_stage);
  endtask

  task automatic drive(input logic st, input logic vld, input int m [8], input int bx);
    bus.start    = st;
    bus.in_valid = vld;
    for (int s = 0; s < 8; s++) bus.acs_ppm_bus_in[s*8 +: 8] = m[s][7:0];
    bus.acs_bx_bus_in = bx[7:0];
  endtask

  // Inputs set at negedge, captured at posedge, checked at the next negedge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    int z   [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int v1  [8] = '{3, 5, 2, 7, 2, 9, 4, 6};
    int v2  [8] = '{130, 128, 200, 255, 140, 129, 160, 170};
    int e2  [8] = '{2, 0, 72, 127, 12, 1, 32, 42};
    int m   [8];
    n_cmp = 0;
    n_err = 0;

    reset_n = 1'b0;
    drive(1'b0, 1'b0, z, 0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("idle ina0", int'(bus.acs_ppm_ina_bus[7:0]), 0);
    chk("idle inb0", int'(bus.acs_ppm_inb_bus[7:0]), 64);
    chk("idle ina3", int'(bus.acs_ppm_ina_bus[31:24]), 64);
    chk("idle dv",   int'(bus.dec_valid), 0);

    drive(1'b1, 1'b0, z, 0);
    cycle();
    drive(1'b0, 1'b1, v1, 8'hA5);
    cycle();
    chk("v1 dv",    int'(bus.dec_valid), 1);
    chk("v1 dec",   int'(bus.dec_out), 8'hA5);
    chk("v1 best",  int'(bus.best_state), 2);
    chk("v1 stage", int'(bus.stage_cnt), 0);
    chk("v1 norm",  int'(bus.norm_evt), 0);
    for (int s = 0; s < 8; s++) chk($sformatf("v1 pm%0d", s), dut_pm(s), v1[s]);

    drive(1'b0, 1'b1, v2, 8'h3C);
    cycle();
    for (int s = 0; s < 8; s++) chk($sformatf("v2 pm%0d", s), dut_pm(s), e2[s]);
    chk("v2 norm",  int'(bus.norm_evt), 1);
    chk("v2 ovf",   int'(bus.ovf), 1);
    chk("v2 best",  int'(bus.best_state), 1);
    chk("v2 stage", int'(bus.stage_cnt), 1);

    drive(1'b0, 1'b0, v1, 0);
    cycle();
    chk("hold ovf", int'(bus.ovf), 1);
    chk("hold dv",  int'(bus.dec_valid), 0);
    chk("hold dec", int'(bus.dec_out), 8'h3C);

    drive(1'b1, 1'b1, v1, 8'hFF);
    cycle();
    chk("st+iv dv",    int'(bus.dec_valid), 0);
    chk("st+iv stage", int'(bus.stage_cnt), 0);
    chk("st+iv ovf",   int'(bus.ovf), 0);
    chk("st+iv pm0",   dut_pm(0), 0);
    chk("st+iv pm5",   dut_pm(5), 64);

    for (int i = 0; i < 65; i++) begin
      for (int s = 0; s < 8; s++) begin
        m[s] = (i * 37 + s * 53 + 7) % 256;
        if (i % 8 == 3) m[s] = m[s] | 128;
      end
      if (i == 20) m[6] = 255;
      drive(1'b0, 1'b1, m, (i * 29) % 256);
      cycle();
      chk("run dv", int'(bus.dec_valid), 1);
      if (i == 63) chk("run stage63", int'(bus.stage_cnt), 63);
      if (i == 64) chk("run wrap",    int'(bus.stage_cnt), 0);
    end

    reset_n = 1'b0;
    drive(1'b0, 1'b1, v2, 8'h77);
    cycle();
    chk("rst dv",    int'(bus.dec_valid), 0);
    chk("rst dec",   int'(bus.dec_out), 0);
    chk("rst best",  int'(bus.best_state), 0);
    chk("rst stage", int'(bus.stage_cnt), 0);
    chk("rst ovf",   int'(bus.ovf), 0);
    chk("rst norm",  int'(bus.norm_evt), 0);
    chk("rst pm0",   dut_pm(0), 0);
    chk("rst pm7",   dut_pm(7), 64);

    reset_n = 1'b1;
    drive(1'b0, 1'b1, v1, 8'h11);
    cycle();
    chk("post stage", int'(bus.stage_cnt), 0);
    drive(1'b0, 1'b1, v2, 8'h22);
    cycle();
    chk("post stage1", int'(bus.stage_cnt), 1);
    drive(1'b0, 1'b0, z, 0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/epmu_213.md
EPMU_213 -- requirements
Module: ePMU_213

Interface
REQ-001 Parameter W, default 8: path-metric width in bits; SHALL match the ACSU metric width.
REQ-002 Parameter SC_W, default 6: stage-counter width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  frame start: (re)initialise metrics.
REQ-006 in_valid  input  1  ACSU outputs valid this cycle.
REQ-007 acs_ppm_bus_in  input  8*W  ACSU survivor metrics; state s at bits [s*W +: W].
REQ-008 acs_bx_bus_in  input  8  ACSU decision bits; bit s = state s.
REQ-009 acs_ppm_ina_bus  output  8*W  feedback metric "a" to ACS s, slice s.
REQ-010 acs_ppm_inb_bus  output  8*W  feedback metric "b" to ACS s, slice s.
REQ-011 dec_out  output  8  registered decision vector to survivor memory.
REQ-012 dec_valid  output  1  dec_out, best_state, stage_cnt valid, one-cycle pulse.
REQ-013 best_state  output  3  index of the minimum-metric state for this stage.
REQ-014 stage_cnt  output  SC_W  index of the stage carried on dec_out.
REQ-015 norm_evt  output  1  normalisation applied on this stage, pulse aligned with dec_valid.
REQ-016 ovf  output  1  sticky metric-saturation flag.

Function
REQ-017 Eight W-bit metric registers PM[0..7] SHALL hold the current path metrics.
REQ-018 Trellis routing (next state ns = {u, s[2:1]}) SHALL drive slice s of acs_ppm_ina_bus from PM[(2s) mod 8], and slice s of acs_ppm_inb_bus from PM[(2s+1) mod 8].
REQ-019 Both routing buses SHALL be purely combinational from PM, with no added latency.
REQ-020 start=1 SHALL set PM[0]=0 and PM[1..7]=2^(W-2).
REQ-021 start=1 SHALL clear stage_cnt and ovf.
REQ-022 start=1 SHALL force dec_valid=0 and norm_evt=0 in the following cycle.
REQ-023 start=1 SHALL take priority over in_valid in the same cycle; the input metrics SHALL be discarded.
REQ-024 in_valid=1 with start=0: if every input metric has its MSB set, PM[s] SHALL load input[s] minus 2^(W-1) and norm_evt SHALL pulse; otherwise PM[s] SHALL load input[s] unchanged.
REQ-025 Under in_valid=1 with start=0, dec_out SHALL load acs_bx_bus_in.
REQ-026 Under in_valid=1 with start=0, best_state SHALL load the index of the minimum input metric; on ties, the lowest index SHALL win; the comparison SHALL use pre-normalisation values.
REQ-027 Under in_valid=1 with start=0, stage_cnt output SHALL carry the internal count value before increment, and the internal count SHALL then increment modulo 2^SC_W with silent wrap.
REQ-028 Under in_valid=1 with start=0, dec_valid SHALL pulse high in the next cycle; latency in_valid to dec_valid SHALL be exactly 1 cycle.
REQ-029 With in_valid=0 and start=0, PM, dec_out, best_state and stage_cnt SHALL hold their values, and dec_valid and norm_evt SHALL be 0.
REQ-030 Any accepted input metric equal to 2^W-1 SHALL set ovf; ovf SHALL stay set until start or reset.
REQ-031 Back-to-back in_valid SHALL be accepted every cycle, with no bubbles and no backpressure.
REQ-032 Normalisation SHALL be exactly one subtraction (MSB clear), applied to all 8 states or to none.

Reset
REQ-033 reset_n=0 at a clock edge SHALL give: PM[0]=0, PM[1..7]=2^(W-2), dec_out=0, dec_valid=0, best_state=0, stage_cnt=0, norm_evt=0, ovf=0.
REQ-034 Reset SHALL override start and in_valid, including when asserted mid-frame.

Verification
REQ-035 Reset then idle -> ina slice0=PM[0]=0, inb slice0=PM[1]=64 (W=8); ina slice3=PM[6]=64; dec_valid=0.
REQ-036 start, then one in_valid with metrics {3,5,2,7,2,9,4,6} and bx=8'hA5 -> next cycle: dec_valid=1, dec_out=A5, best_state=2, stage_cnt=0, norm_evt=0, PM unchanged from input.
REQ-037 in_valid with all metrics >=128 {130,128,200,255,140,129,160,170} -> PM={2,0,72,127,12,1,32,42}, norm_evt=1, ovf=1.
REQ-038 start and in_valid in the same cycle -> PM re-initialised, dec_valid=0 next cycle, stage_cnt=0.
REQ-039 65 consecutive in_valid cycles, SC_W=6 -> stage_cnt runs 0..63 then 0; no dec_valid gaps.
REQ-040 reset_n low mid-stream with in_valid high -> next cycle all outputs at the REQ-033 values, dec_valid=0.
